// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: variable-latency req/ready data-memory access with sub-word
// load/store lanes, alignment check, wait-timeout watchdog and forwarding taps.
module mem_stage_hs #(
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [ADDR_W-1:0] ex_alu_result,
    input  logic [31:0]       ex_write_data,
    input  logic [REG_AW-1:0] ex_dst,
    output logic              fwd_reg_write,
    output logic [REG_AW-1:0] fwd_dst,
    output logic [ADDR_W-1:0] fwd_alu_result,
    output logic              fwd_mem_read,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [31:0]       wb_read_data,
    output logic [ADDR_W-1:0] wb_alu_result,
    output logic [REG_AW-1:0] wb_dst,
    output logic              misalign,
    output logic              bus_err
);

    typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a,
                                           input logic rd);
        if (rd) return 4'b1111;
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] a,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic        timeout;

    logic              access;
    logic              misaligned;
    logic              ex_we;
    logic [ADDR_W-1:0] ex_addr;
    logic [3:0]        ex_be;
    logic [31:0]       ex_wdata;
    logic [31:0]       ex_load;

    logic              req_we_p1;
    logic              req_read_p1;
    logic [ADDR_W-1:0] req_addr_p1;
    logic [3:0]        req_be_p1;
    logic [31:0]       req_wdata_p1;
    logic [1:0]        req_lo_p1;
    logic [1:0]        req_size_p1;
    logic              req_uns_p1;
    logic              req_reg_write_p1;
    logic              req_mem_to_reg_p1;
    logic [ADDR_W-1:0] req_alu_p1;
    logic [REG_AW-1:0] req_dst_p1;

    assign fwd_reg_write  = ex_valid & ex_reg_write & (ex_dst != '0);
    assign fwd_dst        = ex_dst;
    assign fwd_alu_result = ex_alu_result;
    assign fwd_mem_read   = ex_valid & ex_mem_read;

    assign access     = ex_valid & (ex_mem_read | ex_mem_write);
    assign misaligned = access & (((ex_size == 2'b01) & ex_alu_result[0]) |
                                  (ex_size[1] & (ex_alu_result[1:0] != 2'b00)));
    assign ex_we      = ex_mem_write & ~ex_mem_read;
    assign ex_addr    = {ex_alu_result[ADDR_W-1:2], 2'b00};
    assign ex_be      = lane_be(ex_size, ex_alu_result[1:0], ex_mem_read);
    assign ex_wdata   = lane_wdata(ex_size, ex_write_data);
    assign ex_load    = load_ext(mem_rdata, ex_alu_result[1:0], ex_size, ex_unsigned);

    // Once the counter has reached the limit the request is withdrawn for one
    // cycle with stall low, so upstream releases the instruction as it retires.
    assign timeout = (state == ST_WAIT) && (wait_cnt == WAIT_LIM);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mem_req && !mem_ready) state_nxt = ST_WAIT;
            ST_WAIT: if (timeout || mem_ready)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ex_addr;
        mem_be    = ex_be;
        mem_wdata = ex_wdata;
        if (state == ST_WAIT) begin
            mem_req   = ~timeout;
            mem_we    = ~timeout & req_we_p1;
            mem_addr  = req_addr_p1;
            mem_be    = req_be_p1;
            mem_wdata = req_wdata_p1;
        end else begin
            mem_req   = access & ~misaligned;
            mem_we    = access & ~misaligned & ex_we;
        end
    end

    assign stall = mem_req & ~mem_ready;

    always_ff @(posedge clock) begin
        if (reset)                                        wait_cnt <= '0;
        else if (state == ST_WAIT && state_nxt == ST_WAIT) wait_cnt <= wait_cnt + 8'd1;
        else                                              wait_cnt <= '0;
    end

    // p1: request fields captured on issue, replayed on the bus while waiting.
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && mem_req) begin
            req_we_p1         <= ex_we;
            req_read_p1       <= ex_mem_read;
            req_addr_p1       <= ex_addr;
            req_be_p1         <= ex_be;
            req_wdata_p1      <= ex_wdata;
            req_lo_p1         <= ex_alu_result[1:0];
            req_size_p1       <= ex_size;
            req_uns_p1        <= ex_unsigned;
            req_reg_write_p1  <= ex_reg_write;
            req_mem_to_reg_p1 <= ex_mem_to_reg;
            req_alu_p1        <= ex_alu_result;
            req_dst_p1        <= ex_dst;
        end
    end

    // MEM/WB register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_dst        <= '0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            if (timeout) begin
                wb_valid      <= 1'b1;
                wb_reg_write  <= 1'b0;
                wb_mem_to_reg <= req_mem_to_reg_p1;
                wb_read_data  <= '0;
                wb_alu_result <= req_alu_p1;
                wb_dst        <= req_dst_p1;
                bus_err       <= 1'b1;
            end else if (stall) begin
                wb_valid      <= 1'b0;
                wb_reg_write  <= 1'b0;
            end else if (state == ST_WAIT) begin
                wb_valid      <= 1'b1;
                wb_reg_write  <= req_reg_write_p1;
                wb_mem_to_reg <= req_mem_to_reg_p1;
                wb_read_data  <= req_read_p1 ?
                                 load_ext(mem_rdata, req_lo_p1, req_size_p1, req_uns_p1) : '0;
                wb_alu_result <= req_alu_p1;
                wb_dst        <= req_dst_p1;
            end else begin
                wb_valid      <= ex_valid;
                wb_reg_write  <= ex_valid & ex_reg_write & ~misaligned;
                wb_mem_to_reg <= ex_mem_to_reg;
                wb_read_data  <= (access & ex_mem_read & ~misaligned) ? ex_load : '0;
                wb_alu_result <= ex_alu_result;
                wb_dst        <= ex_dst;
                misalign      <= misaligned;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed scenarios followed by randomized transactions
// checked against an arithmetic reference model of the stage's rules.
module tb_mem_stage_hs;

    localparam int TB_MAX_WAIT = 4;

    logic        clock;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [31:0] ex_alu_result, ex_write_data;
    logic [4:0]  ex_dst;
    logic        fwd_reg_write, fwd_mem_read;
    logic [4:0]  fwd_dst;
    logic [31:0] fwd_alu_result;
    logic        stall, mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, misalign, bus_err;
    logic [31:0] wb_read_data, wb_alu_result;
    logic [4:0]  wb_dst;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_hs #(.ADDR_W(32), .REG_AW(5), .MAX_WAIT(TB_MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_alu_result(ex_alu_result),
        .ex_write_data(ex_write_data), .ex_dst(ex_dst),
        .fwd_reg_write(fwd_reg_write), .fwd_dst(fwd_dst),
        .fwd_alu_result(fwd_alu_result), .fwd_mem_read(fwd_mem_read),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_read_data(wb_read_data),
        .wb_alu_result(wb_alu_result), .wb_dst(wb_dst),
        .misalign(misalign), .bus_err(bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
        ex_mem_to_reg = 0; ex_size = 2'b00; ex_unsigned = 0;
        ex_alu_result = 0; ex_write_data = 0; ex_dst = 0;
    endtask

    task automatic set_ex(input logic v, input logic rd, input logic wr, input logic rw,
                          input logic m2r, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] dst);
        ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
        ex_mem_to_reg = m2r; ex_size = size; ex_unsigned = uns;
        ex_alu_result = addr; ex_write_data = wd; ex_dst = dst;
    endtask

    // Reference-model state for the randomized phase.
    logic        r_valid, r_rd, r_wr, r_rw, r_m2r, r_uns;
    logic [1:0]  r_size;
    logic [4:0]  r_dst;
    logic [31:0] r_addr, r_wdata, r_rdata, exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;
    logic [63:0] lv;
    logic        m_access, m_misal;
    int          nbytes, a, lat, kind, req_cycles, stalls;

    initial begin
        reset = 1; mem_ready = 0; mem_rdata = 0;
        idle_inputs();
        tick(); tick();
        check1("rst_wb_valid", wb_valid, 1'b0);
        check1("rst_wb_reg_write", wb_reg_write, 1'b0);
        check32("rst_wb_read_data", wb_read_data, 32'h0);
        check1("rst_misalign", misalign, 1'b0);
        check1("rst_bus_err", bus_err, 1'b0);
        check1("rst_mem_req", mem_req, 1'b0);
        reset = 0;

        // Zero-wait word load
        set_ex(1, 1, 0, 1, 1, 2'b10, 0, 32'h10, 32'h0, 5'd3);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        check1("zw_req", mem_req, 1'b1);
        check1("zw_stall", stall, 1'b0);
        check32("zw_be", 32'(mem_be), 32'hF);
        check32("zw_addr", mem_addr, 32'h10);
        tick();
        check32("zw_rdata", wb_read_data, 32'hDEADBEEF);
        check1("zw_wb_valid", wb_valid, 1'b1);
        check32("zw_wb_dst", 32'(wb_dst), 32'd3);

        // Byte loads at 0x13: lane 3 holds 0x80
        set_ex(1, 1, 0, 1, 1, 2'b00, 0, 32'h13, 32'h0, 5'd8);
        mem_rdata = 32'h80FF_0000;
        #1;
        check32("lb_addr", mem_addr, 32'h10);
        tick();
        check32("lb_signed", wb_read_data, 32'hFFFFFF80);
        ex_unsigned = 1;
        tick();
        check32("lbu_unsigned", wb_read_data, 32'h00000080);

        // Half store at 0x22, ready on the fourth cycle; EX inputs change while waiting
        set_ex(1, 0, 1, 0, 0, 2'b01, 0, 32'h22, 32'h0000ABCD, 5'd0);
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            if (c > 0) begin
                ex_alu_result = 32'h99; ex_write_data = 32'h0;
            end
            #1;
            check1("sh_req", mem_req, 1'b1);
            check1("sh_we", mem_we, 1'b1);
            check32("sh_addr", mem_addr, 32'h20);
            check32("sh_be", 32'(mem_be), 32'hC);
            check32("sh_wdata", mem_wdata, 32'hABCDABCD);
            if (stall) stalls++;
            tick();
            if (c < 3) check1("sh_bubble", wb_valid, 1'b0);
        end
        idle_inputs();
        mem_ready = 0;
        check32("sh_stall_cycles", 32'(stalls), 32'd3);
        check1("sh_wb_valid", wb_valid, 1'b1);
        check32("sh_wb_alu", wb_alu_result, 32'h22);
        check32("sh_wb_rdata", wb_read_data, 32'h0);

        // Misaligned word load
        set_ex(1, 1, 0, 1, 1, 2'b10, 0, 32'h05, 32'h0, 5'd4);
        mem_ready = 1;
        #1;
        check1("mis_no_req", mem_req, 1'b0);
        tick();
        check1("mis_pulse", misalign, 1'b1);
        check1("mis_wb_valid", wb_valid, 1'b1);
        check1("mis_wb_reg_write", wb_reg_write, 1'b0);
        idle_inputs();
        mem_ready = 0;
        tick();
        check1("mis_pulse_end", misalign, 1'b0);

        // Timeout: mem_ready never comes
        set_ex(1, 1, 0, 1, 1, 2'b10, 0, 32'h40, 32'h0, 5'd5);
        req_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!mem_req) break;
            req_cycles++;
            tick();
        end
        check32("to_req_cycles", 32'(req_cycles), 32'(TB_MAX_WAIT + 1));
        check1("to_stall_drop", stall, 1'b0);
        idle_inputs();
        tick();
        check1("to_bus_err", bus_err, 1'b1);
        check1("to_wb_valid", wb_valid, 1'b1);
        check1("to_wb_reg_write", wb_reg_write, 1'b0);
        check1("to_idle_req", mem_req, 1'b0);
        tick();
        check1("to_bus_err_end", bus_err, 1'b0);

        // Forwarding taps
        set_ex(1, 0, 0, 1, 0, 2'b10, 0, 32'h1234, 32'h0, 5'd0);
        #1;
        check1("fwd_dst0", fwd_reg_write, 1'b0);
        check32("fwd_alu", fwd_alu_result, 32'h1234);
        ex_dst = 5'd7;
        #1;
        check1("fwd_dst7", fwd_reg_write, 1'b1);
        check32("fwd_dst", 32'(fwd_dst), 32'd7);
        ex_mem_read = 1;
        #1;
        check1("fwd_mem_read", fwd_mem_read, 1'b1);
        ex_valid = 0;
        #1;
        check1("fwd_mem_read_inv", fwd_mem_read, 1'b0);
        idle_inputs();

        // Reset while waiting aborts the access
        set_ex(1, 1, 0, 1, 1, 2'b10, 0, 32'h80, 32'h0, 5'd9);
        mem_ready = 0;
        tick();
        check1("rw_stall", stall, 1'b1);
        tick();
        reset = 1;
        idle_inputs();
        tick();
        check1("rw_req", mem_req, 1'b0);
        check1("rw_wb_valid", wb_valid, 1'b0);
        check1("rw_wb_reg_write", wb_reg_write, 1'b0);
        check32("rw_wb_dst", 32'(wb_dst), 32'd0);
        check32("rw_wb_alu", wb_alu_result, 32'd0);
        reset = 0;
        mem_ready = 1;
        tick();
        check1("stray_ready_wb", wb_valid, 1'b0);
        check1("stray_ready_stall", stall, 1'b0);
        mem_ready = 0;

        // Randomized transactions against the reference model
        for (int t = 0; t < 150; t++) begin
            r_valid = ($urandom_range(0, 9) != 0);
            kind    = $urandom_range(0, 5);
            r_rd    = (kind <= 1) || (kind == 4);
            r_wr    = (kind == 2) || (kind == 3) || (kind == 4);
            r_rw    = 1'($urandom_range(0, 1));
            r_m2r   = 1'($urandom_range(0, 1));
            r_uns   = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_dst   = 5'($urandom_range(0, 31));
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_addr  = $urandom & 32'h0000_0FFF;
            nbytes  = (r_size == 2'b00) ? 1 : (r_size == 2'b01) ? 2 : 4;
            if ($urandom_range(0, 2) != 0) r_addr = r_addr - (r_addr % nbytes);
            lat     = $urandom_range(0, TB_MAX_WAIT);

            a         = int'(r_addr % 4);
            m_access  = r_valid && (r_rd || r_wr);
            m_misal   = m_access && ((r_addr % nbytes) != 0);
            exp_addr  = r_addr - a;
            exp_be    = r_rd ? 4'hF : 4'(((1 << nbytes) - 1) << a);
            exp_wdata = (nbytes == 1) ? (r_wdata & 32'hFF) * 32'h01010101 :
                        (nbytes == 2) ? (r_wdata & 32'hFFFF) * 32'h00010001 : r_wdata;
            lv = ({32'd0, r_rdata} >> (8 * a)) & ((64'd1 << (8 * nbytes)) - 64'd1);
            if (!r_uns && nbytes < 4 && lv >= (64'd1 << (8 * nbytes - 1)))
                lv = lv - (64'd1 << (8 * nbytes));
            exp_rd = lv[31:0];

            set_ex(r_valid, r_rd, r_wr, r_rw, r_m2r, r_size, r_uns, r_addr, r_wdata, r_dst);
            mem_rdata = r_rdata;

            if (m_access && !m_misal) begin
                for (int c = 0; c <= lat; c++) begin
                    mem_ready = (c == lat);
                    #1;
                    check1("rnd_req", mem_req, 1'b1);
                    check1("rnd_we", mem_we, !r_rd);
                    check32("rnd_addr", mem_addr, exp_addr);
                    check32("rnd_be", 32'(mem_be), 32'(exp_be));
                    if (!r_rd) check32("rnd_wdata", mem_wdata, exp_wdata);
                    check1("rnd_stall", stall, c != lat);
                    tick();
                    if (c < lat) check1("rnd_bubble", wb_valid, 1'b0);
                end
                idle_inputs();
                mem_ready = 0;
                check1("rnd_wb_valid", wb_valid, 1'b1);
                check1("rnd_wb_reg_write", wb_reg_write, r_rw);
                check1("rnd_wb_m2r", wb_mem_to_reg, r_m2r);
                check32("rnd_wb_rdata", wb_read_data, r_rd ? exp_rd : 32'h0);
                check32("rnd_wb_alu", wb_alu_result, r_addr);
                check32("rnd_wb_dst", 32'(wb_dst), 32'(r_dst));
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                check1("rnd_noreq", mem_req, 1'b0);
                check1("rnd_nostall", stall, 1'b0);
                tick();
                check1("rnd_nm_valid", wb_valid, r_valid);
                check1("rnd_nm_reg_write", wb_reg_write, r_valid && r_rw && !m_misal);
                check1("rnd_nm_misalign", misalign, m_misal);
                check32("rnd_nm_rdata", wb_read_data, 32'h0);
                idle_inputs();
                mem_ready = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Next-generation MEM pipeline stage for the 5-stage MIPS core. It sits between the EX/MEM and MEM/WB registers. It talks to data memory over a req/ready handshake with variable latency, and stalls upstream stages until the access completes. It adds byte/halfword loads and stores with sign/zero extension, alignment checking, a wait-timeout watchdog, and forwarding outputs that are gated by valid and by a zero destination.

Parameters:
ADDR_W, 32, width of memory address / ALU result
REG_AW, 5, register-file index width
MAX_WAIT, 15, max cycles spent in WAIT before bus_err (1..255)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
ex_valid  in  1  EX/MEM holds a live instruction
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_reg_write  in  1  writes register file
ex_mem_to_reg  in  1  WB selects read data
ex_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
ex_unsigned  in  1  zero-extend load
ex_alu_result  in  ADDR_W  address / ALU value
ex_write_data  in  32  store data
ex_dst  in  REG_AW  destination register
fwd_reg_write  out  1  ex_valid & ex_reg_write & (ex_dst!=0), combinational
fwd_dst  out  REG_AW  ex_dst
fwd_alu_result  out  ADDR_W  ex_alu_result
fwd_mem_read  out  1  ex_valid & ex_mem_read
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
mem_req  out  1  access request
mem_we  out  1  write access
mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ready  in  1  access complete this cycle
mem_rdata  in  32  read data, valid with mem_ready
wb_valid  out  1  MEM/WB valid
wb_reg_write  out  1  registered
wb_mem_to_reg  out  1  registered
wb_read_data  out  32  extended load data
wb_alu_result  out  ADDR_W  registered
wb_dst  out  REG_AW  registered
misalign  out  1  one-cycle pulse with the faulting instruction in WB
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE, wait counter 0. All wb_* outputs, misalign and bus_err are 0. mem_req is 0.
- access = ex_valid & (ex_mem_read|ex_mem_write). Only one of read/write may be set; if both are set, read wins.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No mem_req is issued. Next edge: wb_valid=1, wb_reg_write=0, misalign=1.
- IDLE, aligned access: mem_req=1 combinationally from ex_* inputs; request fields are latched on the same edge.
  - If mem_ready=1 in the same cycle, the access completes with zero wait, behaving like a single-cycle memory.
  - Otherwise stall=1 and the next state is WAIT.
- WAIT: mem_req=1, driven from the latched request, which stays stable. stall=1 until the cycle mem_ready=1 (stall=0 in that cycle). On mem_ready the stage returns to IDLE.
- stall = mem_req & ~mem_ready.
- Wait counter: increments each WAIT cycle. If the counter reaches MAX_WAIT without mem_ready: drop the request, pulse bus_err, write MEM/WB with wb_valid=1, wb_reg_write=0, then go to IDLE. The counter clears on leaving WAIT.
- MEM/WB update:
  - While stall=1, MEM/WB receives a bubble: wb_valid=0, wb_reg_write=0, and the other wb_* values are held.
  - On a completing or non-memory cycle, it loads from the ex_* inputs, or from the latched fields for a WAIT completion.
  - For non-access instructions, wb_read_data=0.
- Store: mem_be is 0001<<a for byte, 0011<<a for half, 1111 for word, where a = addr[1:0]. mem_wdata is {4{b}} for byte, {2{h}} for half, or the full word.
- Load (little-endian): select lane addr[1:0] for byte or addr[1] for half. Sign-extend unless ex_unsigned is set. Loads use mem_be=1111.
- A mem_ready arriving while no request is outstanding is ignored.
- Reset during WAIT aborts the access: state returns to IDLE, mem_req=0 in the next cycle, and no wb write occurs.

Test Plan:
- Zero-wait word load: addr 0x10, mem_ready tied 1, rdata 0xDEADBEEF -> next edge wb_read_data=0xDEADBEEF, wb_valid=1, stall never 1.
- Byte load signed/unsigned: addr 0x13, rdata 0x80FF_0000 -> signed wb_read_data=0xFFFFFF80; unsigned -> 0x00000080.
- Half store at addr 0x22, data 0x0000ABCD, ready after 3 cycles -> mem_be=1100, mem_wdata=0xABCDABCD; stall=1 for 3 cycles; mem_addr/be stable; wb_valid=0 during stall, 1 after.
- Misaligned word load at 0x05 -> no mem_req; next cycle misalign=1, wb_valid=1, wb_reg_write=0.
- Timeout with MAX_WAIT=4, mem_ready held 0 -> bus_err pulses after 4 WAIT cycles, mem_req drops, stall drops, state IDLE.
- Forwarding: ex_dst=0, ex_reg_write=1 -> fwd_reg_write=0; reset asserted in WAIT -> mem_req=0 and all wb_* outputs 0 at the next edge.
